// File: rtl/axi_ax_arbiter_if.sv
// Address-channel arbiter bundle: master requests, slave ready, granted-path
// data handshake in; one-hot grant, gated per-master readies, status out.
// Ports: slave modport = arbiter side, master modport = requester/driver side.
interface axi_ax_arbiter_if #(
  parameter int LEN_W = 4
);
  logic             AXVALID_M0;
  logic             AXVALID_M1;
  logic             AXREADY_S;
  logic [LEN_W-1:0] AXLEN;
  logic             DVALID;
  logic             DREADY;
  logic             DLAST;
  logic [1:0]       gnt;
  logic             AXREADY_M0;
  logic             AXREADY_M1;
  logic             busy;
  logic             len_err;

  modport slave (
    input  AXVALID_M0, AXVALID_M1, AXREADY_S, AXLEN, DVALID, DREADY, DLAST,
    output gnt, AXREADY_M0, AXREADY_M1, busy, len_err
  );

  modport master (
    output AXVALID_M0, AXVALID_M1, AXREADY_S, AXLEN, DVALID, DREADY, DLAST,
    input  gnt, AXREADY_M0, AXREADY_M1, busy, len_err
  );
endinterface

// File: rtl/axi_ax_arbiter.sv
// Two-master AXI3 address-channel arbiter; grant held from address accept to last data beat.
// Latency: request sampled in cycle N -> registered gnt in N+1; AxREADY is combinational from gnt.
// Backpressure: AXREADY_S passes only to the granted master in ADDR; data path is never stalled here.
//
// Ports: ACLK, ARESETn (sync active-low); bus (slave modport): AXVALID_M0/M1, AXREADY_S, AXLEN,
// DVALID/DREADY/DLAST of the granted path in; gnt (one-hot), AXREADY_M0/M1, busy, len_err out.
// Build option: define AXI_ARB_RR_EN for round-robin on ties; otherwise M0 has fixed priority.
module axi_ax_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_ax_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       gnt_q;
  logic             last_owner;   // 0 = M0 owned the previous burst, 1 = M1
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             err_seen;
  logic             busy_q;
  logic             len_err_q;

  logic [1:0]       win;
  logic             req_any;
  logic             addr_hs;
  logic             beat;
  logic             len_bad;

  assign req_any = bus.AXVALID_M0 | bus.AXVALID_M1;

  // Winner for the IDLE -> ADDR transition.
  always_comb begin
    win = 2'b00;
    if (bus.AXVALID_M0 && !bus.AXVALID_M1) begin
      win = 2'b01;
    end else if (bus.AXVALID_M1 && !bus.AXVALID_M0) begin
      win = 2'b10;
    end else if (bus.AXVALID_M0 && bus.AXVALID_M1) begin
`ifdef AXI_ARB_RR_EN
      // Tie goes to whoever did not own the previous burst.
      win = last_owner ? 2'b01 : 2'b10;
`else
      win = 2'b01;
`endif
    end
  end

  // Address handshake only counts for the granted master's valid.
  assign addr_hs = (state == ADDR) && bus.AXREADY_S &&
                   ((gnt_q[0] && bus.AXVALID_M0) || (gnt_q[1] && bus.AXVALID_M1));

  assign beat = (state == DATA) && bus.DVALID && bus.DREADY;

  // Early DLAST, or the expected last beat arriving without DLAST.
  assign len_bad = bus.DLAST ? (beat_cnt != len_q) : (beat_cnt == len_q);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= IDLE;
      gnt_q      <= 2'b00;
      last_owner <= 1'b1;
      len_q      <= '0;
      beat_cnt   <= '0;
      err_seen   <= 1'b0;
      busy_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt_q  <= win;
            state  <= ADDR;
            busy_q <= 1'b1;
          end
        end
        ADDR: begin
          if (addr_hs) begin
            len_q    <= bus.AXLEN;
            beat_cnt <= '0;
            err_seen <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (len_bad && !err_seen) begin
              len_err_q <= 1'b1;
              err_seen  <= 1'b1;
            end
            // Release is tied to DLAST only; a length mismatch never frees the grant early.
            if (bus.DLAST) begin
              state      <= IDLE;
              gnt_q      <= 2'b00;
              busy_q     <= 1'b0;
              last_owner <= gnt_q[1];
            end
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= 2'b00;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.len_err    = len_err_q;
  // Ready reaches a master only while its address is pending; DATA keeps both at 0.
  assign bus.AXREADY_M0 = bus.AXREADY_S && gnt_q[0] && (state == ADDR);
  assign bus.AXREADY_M1 = bus.AXREADY_S && gnt_q[1] && (state == ADDR);

endmodule

// File: tb/tb_axi_ax_arbiter.sv
module tb_axi_ax_arbiter;

  logic ACLK;
  logic ARESETn;
  int   errors;
  int   checks;

  axi_ax_arbiter_if #(.LEN_W(4)) bus_if ();

  axi_ax_arbiter #(.LEN_W(4)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus_if)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus_if.AXVALID_M0 = 1'b0;
    bus_if.AXVALID_M1 = 1'b0;
    bus_if.AXREADY_S  = 1'b0;
    bus_if.AXLEN      = 4'd0;
    bus_if.DVALID     = 1'b0;
    bus_if.DREADY     = 1'b0;
    bus_if.DLAST      = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    idle_inputs();
    bus_if.AXVALID_M0 = 1'b1;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    repeat (3) step();
    #1;
    checks++;
    if (bus_if.gnt !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", bus_if.gnt);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    end
    checks++;
    if (bus_if.AXREADY_M0 !== 1'b0 || bus_if.AXREADY_M1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", bus_if.AXREADY_M1, bus_if.AXREADY_M0);
    end
    checks++;
    if (bus_if.len_err !== 1'b0) begin
      errors++; $display("FAIL reset_len_err: got %b expected 0", bus_if.len_err);
    end
    idle_inputs();
    ARESETn = 1'b1;
    step();
  endtask

  task automatic test_single_m1;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd3;
    #1;
    checks++;
    if (bus_if.gnt !== 2'b00) begin
      errors++; $display("FAIL single_pre_gnt: got %b expected 00", bus_if.gnt);
    end
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b10 || bus_if.AXREADY_M1 !== 1'b1 || bus_if.AXREADY_M0 !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b rdy1=%b rdy0=%b busy=%b expected gnt=10 rdy1=1 rdy0=0 busy=1",
               bus_if.gnt, bus_if.AXREADY_M1, bus_if.AXREADY_M0, bus_if.busy);
    end
    step();
    bus_if.AXVALID_M1 = 1'b0;
    #1;
    checks++;
    if (bus_if.AXREADY_M1 !== 1'b0 || bus_if.gnt !== 2'b10 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_data_entry: got rdy1=%b gnt=%b busy=%b expected rdy1=0 gnt=10 busy=1",
               bus_if.AXREADY_M1, bus_if.gnt, bus_if.busy);
    end
    for (int i = 0; i < 4; i++) begin
      bus_if.DVALID = 1'b1;
      bus_if.DREADY = 1'b1;
      bus_if.DLAST  = (i == 3);
      step(); #1;
      checks++;
      if (bus_if.len_err !== 1'b0) begin
        errors++; $display("FAIL single_len_err beat%0d: got %b expected 0", i, bus_if.len_err);
      end
      checks++;
      if (i < 3) begin
        if (bus_if.gnt !== 2'b10 || bus_if.busy !== 1'b1) begin
          errors++; $display("FAIL single_hold beat%0d: got gnt=%b busy=%b expected gnt=10 busy=1", i, bus_if.gnt, bus_if.busy);
        end
      end else begin
        if (bus_if.gnt !== 2'b00 || bus_if.busy !== 1'b0) begin
          errors++; $display("FAIL single_release: got gnt=%b busy=%b expected gnt=00 busy=0", bus_if.gnt, bus_if.busy);
        end
      end
    end
    idle_inputs();
    step(); #1;
    checks++;
    if (bus_if.len_err !== 1'b0 || bus_if.gnt !== 2'b00) begin
      errors++; $display("FAIL single_after: got len_err=%b gnt=%b expected 0 00", bus_if.len_err, bus_if.gnt);
    end
  endtask

  task automatic test_tie_sequence;
    logic [1:0] exp_seq [4];
    int c;
`ifdef AXI_ARB_RR_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    bus_if.AXVALID_M0 = 1'b1;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd0;
    for (int b = 0; b < 4; b++) begin
      c = 0;
      while (bus_if.gnt === 2'b00 && c < 8) begin
        step(); #1;
        c++;
      end
      checks++;
      if (bus_if.gnt !== exp_seq[b]) begin
        errors++; $display("FAIL tie_grant%0d: got %b expected %b", b, bus_if.gnt, exp_seq[b]);
      end
      step();
      bus_if.DVALID = 1'b1;
      bus_if.DREADY = 1'b1;
      bus_if.DLAST  = 1'b1;
      step(); #1;
      checks++;
      if (bus_if.gnt !== 2'b00 || bus_if.len_err !== 1'b0) begin
        errors++; $display("FAIL tie_bubble%0d: got gnt=%b len_err=%b expected 00 0", b, bus_if.gnt, bus_if.len_err);
      end
      bus_if.DVALID = 1'b0;
      bus_if.DREADY = 1'b0;
      bus_if.DLAST  = 1'b0;
      if (b == 3) begin
        bus_if.AXVALID_M0 = 1'b0;
        bus_if.AXVALID_M1 = 1'b0;
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure;
    bus_if.AXVALID_M0 = 1'b1;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b0;
    bus_if.AXLEN      = 4'd0;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b01) begin
      errors++; $display("FAIL bp_grant: got %b expected 01", bus_if.gnt);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_if.gnt !== 2'b01 || bus_if.AXREADY_M0 !== 1'b0 || bus_if.AXREADY_M1 !== 1'b0 || bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall%0d: got gnt=%b rdy0=%b rdy1=%b busy=%b expected 01 0 0 1",
                 i, bus_if.gnt, bus_if.AXREADY_M0, bus_if.AXREADY_M1, bus_if.busy);
      end
      step(); #1;
    end
    // A beat presented during the address handshake must not be counted.
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXVALID_M1 = 1'b0;
    bus_if.DVALID     = 1'b1;
    bus_if.DREADY     = 1'b1;
    bus_if.DLAST      = 1'b0;
    #1;
    checks++;
    if (bus_if.AXREADY_M0 !== 1'b1 || bus_if.AXREADY_M1 !== 1'b0) begin
      errors++; $display("FAIL bp_release_ready: got rdy0=%b rdy1=%b expected 1 0", bus_if.AXREADY_M0, bus_if.AXREADY_M1);
    end
    step();
    bus_if.AXVALID_M0 = 1'b0;
    bus_if.DLAST      = 1'b1;
    #1;
    checks++;
    if (bus_if.AXREADY_M0 !== 1'b0 || bus_if.gnt !== 2'b01 || bus_if.busy !== 1'b1) begin
      errors++; $display("FAIL bp_data: got rdy0=%b gnt=%b busy=%b expected 0 01 1", bus_if.AXREADY_M0, bus_if.gnt, bus_if.busy);
    end
    step(); #1;
    checks++;
    if (bus_if.len_err !== 1'b0 || bus_if.gnt !== 2'b00) begin
      errors++; $display("FAIL bp_hs_beat_uncounted: got len_err=%b gnt=%b expected 0 00", bus_if.len_err, bus_if.gnt);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_short_burst;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd3;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b10) begin
      errors++; $display("FAIL short_grant: got %b expected 10", bus_if.gnt);
    end
    step();
    bus_if.AXVALID_M1 = 1'b0;
    bus_if.DVALID     = 1'b1;
    bus_if.DREADY     = 1'b1;
    bus_if.DLAST      = 1'b0;
    step(); #1;
    checks++;
    if (bus_if.len_err !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++; $display("FAIL short_beat0: got len_err=%b busy=%b expected 0 1", bus_if.len_err, bus_if.busy);
    end
    bus_if.DLAST = 1'b1;
    step(); #1;
    checks++;
    if (bus_if.len_err !== 1'b1 || bus_if.gnt !== 2'b00 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL short_err_release: got len_err=%b gnt=%b busy=%b expected 1 00 0", bus_if.len_err, bus_if.gnt, bus_if.busy);
    end
    idle_inputs();
    step(); #1;
    checks++;
    if (bus_if.len_err !== 1'b0) begin
      errors++; $display("FAIL short_pulse_width: got %b expected 0", bus_if.len_err);
    end
  endtask

  task automatic test_missing_last;
    int pulses;
    pulses = 0;
    bus_if.AXVALID_M0 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd1;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b01) begin
      errors++; $display("FAIL miss_grant: got %b expected 01", bus_if.gnt);
    end
    step();
    bus_if.AXVALID_M0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.DVALID = 1'b1;
      bus_if.DREADY = 1'b1;
      bus_if.DLAST  = (i == 3);
      step(); #1;
      if (bus_if.len_err === 1'b1) pulses++;
      checks++;
      if (bus_if.len_err !== (i == 1)) begin
        errors++; $display("FAIL miss_err beat%0d: got %b expected %b", i, bus_if.len_err, (i == 1));
      end
      checks++;
      if (i < 3) begin
        if (bus_if.busy !== 1'b1 || bus_if.gnt !== 2'b01) begin
          errors++; $display("FAIL miss_hold beat%0d: got busy=%b gnt=%b expected 1 01", i, bus_if.busy, bus_if.gnt);
        end
      end else begin
        if (bus_if.busy !== 1'b0 || bus_if.gnt !== 2'b00) begin
          errors++; $display("FAIL miss_release: got busy=%b gnt=%b expected 0 00", bus_if.busy, bus_if.gnt);
        end
      end
    end
    idle_inputs();
    step(); #1;
    if (bus_if.len_err === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL miss_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_burst;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd3;
    step();
    step();
    bus_if.AXVALID_M1 = 1'b0;
    bus_if.DVALID     = 1'b1;
    bus_if.DREADY     = 1'b1;
    bus_if.DLAST      = 1'b0;
    step();
    ARESETn = 1'b0;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b00 || bus_if.busy !== 1'b0 || bus_if.len_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got gnt=%b busy=%b len_err=%b expected 00 0 0", bus_if.gnt, bus_if.busy, bus_if.len_err);
    end
    ARESETn = 1'b1;
    idle_inputs();
    bus_if.AXVALID_M0 = 1'b1;
    bus_if.AXVALID_M1 = 1'b1;
    bus_if.AXREADY_S  = 1'b1;
    bus_if.AXLEN      = 4'd0;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b01) begin
      errors++; $display("FAIL rst_tie_m0: got %b expected 01", bus_if.gnt);
    end
    step();
    bus_if.AXVALID_M0 = 1'b0;
    bus_if.AXVALID_M1 = 1'b0;
    bus_if.DVALID     = 1'b1;
    bus_if.DREADY     = 1'b1;
    bus_if.DLAST      = 1'b1;
    step(); #1;
    checks++;
    if (bus_if.gnt !== 2'b00 || bus_if.len_err !== 1'b0) begin
      errors++; $display("FAIL rst_after_burst: got gnt=%b len_err=%b expected 00 0", bus_if.gnt, bus_if.len_err);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    ARESETn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_m1();
    test_tie_sequence();
    test_backpressure();
    test_short_burst();
    test_missing_last();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ax_arbiter.md
# axi_ax_arbiter

Two-master arbiter for one AXI3 address channel (AW or AR) of the 2M/2S interconnect. Drives the one-hot `gnt` select of the channel's address mux and W mux, and gates each master's AxREADY. Holds the grant from address acceptance through the last data beat, so address and data of a burst always come from the same master. One instance serves the write path and one serves the read path.

## Interface

Parameters:
- `LEN_W`, default 4: burst-length field width (`AXI_LEN_BITS`).

Ports (reset is synchronous and active-low, sampled on the ACLK rising edge):
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: synchronous active-low reset.
- `AXVALID_M0` in 1: address valid from master 0.
- `AXVALID_M1` in 1: address valid from master 1.
- `AXREADY_S` in 1: address ready from the decoded target slave, post-decoder.
- `AXLEN` in `LEN_W`: burst length from the mux output, valid while granted.
- `DVALID` in 1: data-beat valid of the granted path (W or R).
- `DREADY` in 1: data-beat ready of the granted path.
- `DLAST` in 1: last flag of the granted path's data beat.
- `gnt` out 2: one-hot grant (bit0 = M0, bit1 = M1); 2'b00 = none.
- `AXREADY_M0` out 1: address ready returned to master 0.
- `AXREADY_M1` out 1: address ready returned to master 1.
- `busy` out 1: high in ADDR or DATA.
- `len_err` out 1: one-cycle pulse on a burst-length mismatch.

## Operation

- FSM states: IDLE, ADDR, DATA.
- Registered state: `state`, `gnt`, `last_owner` (1 bit), `len_q`, `beat_cnt` (`LEN_W` bits), `err_seen`.
- IDLE:
  - `gnt = 00`.
  - If any AXVALID_Mx is high, select a winner, load its one-hot `gnt`, and go to ADDR.
- ADDR:
  - `gnt` held.
  - `AXREADY_Mx = AXREADY_S & gnt[x]`, combinational.
  - On `AXVALID_Mgnt & AXREADY_S`: capture `len_q = AXLEN`, clear `beat_cnt` and `err_seen`, go to DATA.
  - A master deasserting valid in ADDR is an AXI violation. The grant is still held; there is no timeout.
- DATA:
  - `gnt` held; both AXREADY_Mx are 0.
  - Each beat (`DVALID & DREADY`) increments `beat_cnt`, wrapping modulo 2^LEN_W.
  - Beat with DLAST: go to IDLE and set `last_owner` to the current owner.
- Winner selection (see Configuration):
  - Single requester: that requester wins.
  - Both requesting: winner depends on `ARB_RR_EN`.
- `len_err` pulses on a beat, at most once per burst (suppressed once `err_seen` is set), when either holds:
  - DLAST and `beat_cnt != len_q`;
  - not DLAST and `beat_cnt == len_q`.
- Release still waits for DLAST.
- Reset values: `state = IDLE`, `gnt = 00`, `last_owner = 1` (M0 first), `AXREADY_M0 = AXREADY_M1 = 0`, `busy = 0`, `len_err = 0`, `beat_cnt = 0`, `len_q = 0`.
- Reset asserted mid-burst aborts to the reset state on that edge. No beat is counted and no pulse is emitted in that cycle.

## Timing

- Request to grant: AXVALID sampled high in cycle N → `gnt` valid in cycle N+1 (registered).
- Earliest address handshake is cycle N+1.
- `AXREADY_Mx` is combinational from `AXREADY_S` and registered `gnt`; there is no added ready latency.
- Address handshake at edge K → DATA from K+1. A data beat in that same cycle K is not counted.
- Last-beat handshake at edge L → IDLE in L+1 with `gnt = 00`.
- A new request can be granted in L+2, which is one idle bubble per burst.
- `len_err` is registered and asserts the cycle after the offending beat.
- `busy = (state != IDLE)`, registered.

## Configuration

- `AXI_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests the master that is not `last_owner` wins.
  - Two continuously requesting masters alternate M0, M1, M0, …
- `AXI_ARB_RR_EN` undefined: fixed priority, M0 always wins ties.
  - `last_owner` is still maintained but ignored.

## Test plan

- Single M1 request:
  - Stimulus: AXVALID_M1 = 1 at cycle 2, AXREADY_S = 1, AXLEN = 3, 4 beats with DLAST on the 4th.
  - Required: `gnt = 10` at cycle 3, AXREADY_M1 = 1 at cycle 3, `busy` through the last beat, `gnt = 00` after, `len_err` never.
- Simultaneous requests, RR on:
  - Stimulus: both masters request continuously, AXLEN = 0, single-beat bursts.
  - Required: grant sequence M0, M1, M0, M1. With the macro off: M0, M0, M0.
- Ready backpressure:
  - Stimulus: AXREADY_S = 0 for 5 cycles after grant.
  - Required: `gnt` stable; AXREADY_M0 = AXREADY_M1 = 0 throughout; handshake on the cycle AXREADY_S rises.
- Short burst:
  - Stimulus: AXLEN = 3, DLAST on the 2nd beat.
  - Required: `len_err` pulses one cycle after the 2nd beat; release to IDLE.
- Missing DLAST:
  - Stimulus: AXLEN = 1, DLAST first on the 4th beat.
  - Required: exactly one `len_err` pulse, after the 2nd beat; release only after the 4th beat.
- Reset mid-burst:
  - Stimulus: ARESETn = 0 for 1 cycle during DATA.
  - Required: next cycle `gnt = 00`, `busy = 0`; the next tie is granted to M0.
